// File: rtl/fetch_prefetcher_if.sv
// fetch_prefetcher_if: redirect, memory request/response and downstream write bundle of the prefetcher
interface fetch_prefetcher_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic                           redirect_valid_i;
   logic [AddrWidth-1:0]           redirect_pc_i;
   logic                           mem_req_valid_o;
   logic [AddrWidth-1:0]           mem_req_addr_o;
   logic                           mem_req_ready_i;
   logic                           mem_rsp_valid_i;
   logic [DataWidth-1:0]           mem_rsp_data_i;
   logic                           wr_valid_o;
   logic [AddrWidth+DataWidth-1:0] wr_data_o;
   logic                           wr_ready_i;
   modport master (
      input  redirect_valid_i, redirect_pc_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, wr_ready_i,
      output mem_req_valid_o, mem_req_addr_o, wr_valid_o, wr_data_o
   );
   modport slave (
      output redirect_valid_i, redirect_pc_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, wr_ready_i,
      input  mem_req_valid_o, mem_req_addr_o, wr_valid_o, wr_data_o
   );
endinterface

// File: rtl/fetch_prefetcher.sv
// fetch_prefetcher: credit-bounded in-order instruction prefetcher with redirect flush; FETCH_PREFETCHER_STATS_EN enables the credit-stall counter
module fetch_prefetcher #(
   parameter int                   MaxOutstanding = 4,
   parameter int                   AddrWidth      = 32,
   parameter int                   DataWidth      = 32,
   parameter logic [AddrWidth-1:0] ResetPc        = '0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   fetch_prefetcher_if.master  bus,
   output logic [31:0]         stall_cnt_o
);
   localparam int PW = $clog2(MaxOutstanding);
   localparam int CW = PW + 1;
   localparam logic [CW:0] MaxCr = (CW+1)'(MaxOutstanding);
   localparam logic [AddrWidth-1:0] Step = AddrWidth'(DataWidth / 8);
   logic [AddrWidth-1:0] req_pc, out_pc;
   logic [CW-1:0]        outstanding, drop_cnt, buf_count;
   logic [PW-1:0]        rd_ptr, wr_ptr;
   logic [DataWidth-1:0] buf_mem [MaxOutstanding];
   logic [CW:0]          credit;
   logic                 req_hs, pop, rsp_drop, rsp_take;
   assign credit = {1'b0, outstanding} + {1'b0, buf_count} + {1'b0, drop_cnt};
   assign bus.mem_req_valid_o = !rst_i && credit < MaxCr;
   assign bus.mem_req_addr_o = req_pc;
   assign bus.wr_valid_o = !rst_i && buf_count != '0;
   assign bus.wr_data_o = bus.wr_valid_o ? {out_pc, buf_mem[rd_ptr]} : '0;
   assign req_hs = bus.mem_req_valid_o && bus.mem_req_ready_i;
   assign pop = bus.wr_valid_o && bus.wr_ready_i;
   assign rsp_drop = bus.mem_rsp_valid_i && drop_cnt != '0;
   assign rsp_take = bus.mem_rsp_valid_i && drop_cnt == '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_pc      <= ResetPc;
         out_pc      <= ResetPc;
         outstanding <= '0;
         drop_cnt    <= '0;
         buf_count   <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (bus.redirect_valid_i) begin
         req_pc      <= bus.redirect_pc_i;
         out_pc      <= bus.redirect_pc_i;
         outstanding <= '0;
         // every response in this cycle is discarded, whichever counter it was charged to
         drop_cnt    <= drop_cnt + outstanding + CW'(req_hs) - CW'(bus.mem_rsp_valid_i);
         buf_count   <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         if (req_hs) req_pc <= req_pc + Step;
         if (pop) out_pc <= out_pc + Step;
         outstanding <= outstanding + CW'(req_hs) - CW'(rsp_take);
         drop_cnt    <= drop_cnt - CW'(rsp_drop);
         buf_count   <= buf_count + CW'(rsp_take) - CW'(pop);
         if (rsp_take) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i && !bus.redirect_valid_i && rsp_take) buf_mem[wr_ptr] <= bus.mem_rsp_data_i;
   end
`ifdef FETCH_PREFETCHER_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) stall_cnt_o <= '0;
      else if (!bus.mem_req_valid_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`else
   assign stall_cnt_o = '0;
`endif
endmodule
